// File: rtl/proc_pkg.sv
// Shared processor definitions: PC select codes,
// fetch buffering depth and the default reset PC.
package proc_pkg;

   localparam logic [1:0] PC_SEL_P4  = 2'd0;
   localparam logic [1:0] PC_SEL_BR  = 2'd1;
   localparam logic [1:0] PC_SEL_JAL = 2'd2;
   localparam logic [1:0] PC_SEL_JR  = 2'd3;

   localparam int FETCH_DEPTH = 3;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small register FIFO with flush; head is read straight from storage.
// Ports: clk/rst, flush, enq/enq_data, deq, head, count.
module fetch_queue
   import proc_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = FETCH_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          enq,
   input  logic [W-1:0]  enq_data,
   input  logic          deq,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic          do_enq;
   logic          do_deq;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // a full queue still accepts when its head leaves this cycle
   assign do_deq = deq & (cnt != '0);
   assign do_enq = enq & ((cnt != CW'(DEPTH)) | do_deq);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_enq) wr_ptr <= nxt(wr_ptr);
         if (do_deq) rd_ptr <= nxt(rd_ptr);
         cnt <= cnt + CW'(do_enq) - CW'(do_deq);
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= enq_data;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/proc_fetch.sv
// Instruction fetch: credit-limited requests, PC tracking, redirect drop.
// Ports: clk/rst, pc select+targets, imemreq/imemresp, inst/pc to decode.
module proc_fetch
   import proc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  c2d_pc_sel_F,
   input  logic [31:0] br_targ_X,
   input  logic [31:0] jal_targ_D,
   input  logic [31:0] jr_targ_D,
   output logic        imemreq_val,
   input  logic        imemreq_rdy,
   output logic [31:0] imemreq_addr,
   input  logic        imemresp_val,
   input  logic [31:0] imemresp_data,
   output logic        inst_val_D,
   input  logic        inst_rdy_D,
   output logic [31:0] inst_D,
   output logic [31:0] pc_D
);

   localparam int CW = $clog2(FETCH_DEPTH + 1);

   logic [31:0]  pc_F;
   logic [1:0]   inflight;
   logic [1:0]   drop_cnt;
   logic [31:0]  targ;
   logic         redirect;
   logic         fire;
   logic         resp;
   logic         keep;
   logic         deq;
   logic         credit;
   logic [CW-1:0] pcq_cnt;
   logic [CW-1:0] ibuf_cnt;
   logic [31:0]   pcq_head;
   fetch_entry_t  ibuf_head;
   fetch_entry_t  ibuf_in;

   assign redirect = (c2d_pc_sel_F != PC_SEL_P4);

   always_comb begin
      targ = pc_F;
      unique case (1'b1)
         (c2d_pc_sel_F == PC_SEL_BR):  targ = br_targ_X;
         (c2d_pc_sel_F == PC_SEL_JAL): targ = jal_targ_D;
         (c2d_pc_sel_F == PC_SEL_JR):  targ = jr_targ_D;
         default:                      targ = pc_F;
      endcase
   end

   // outstanding plus buffered may never exceed the buffer depth
   assign credit = (3'(inflight) + 3'(ibuf_cnt)) < 3'(FETCH_DEPTH);

   assign imemreq_val  = ~rst & ~redirect & credit;
   assign imemreq_addr = pc_F;
   assign fire         = imemreq_val & imemreq_rdy;
   assign resp         = imemresp_val & ~rst;

   // pcq_cnt guard is redundant in normal operation
   assign keep = resp & ~redirect & (drop_cnt == 2'd0)
               & (pcq_cnt != '0);

   assign inst_val_D = ~rst & (ibuf_cnt != '0);
   assign deq        = inst_val_D & inst_rdy_D;
   assign inst_D     = inst_val_D ? ibuf_head.inst : '0;
   assign pc_D       = inst_val_D ? ibuf_head.pc : '0;

   assign ibuf_in.pc   = pcq_head;
   assign ibuf_in.inst = imemresp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_F     <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight + 2'(fire) - 2'(resp);
         if (redirect) begin
            pc_F <= targ;
            // a response arriving now is dropped but not counted
            drop_cnt <= inflight - 2'(resp);
         end else begin
            if (fire) pc_F <= pc_F + 32'd4;
            if (resp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
         end
      end
   end

   fetch_queue #(.W(32), .DEPTH(FETCH_DEPTH)) u_pcq (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .enq      (fire),
      .enq_data (pc_F),
      .deq      (keep),
      .head     (pcq_head),
      .count    (pcq_cnt)
   );

   fetch_queue #(.W(64), .DEPTH(FETCH_DEPTH)) u_ibuf (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .enq      (keep),
      .enq_data (ibuf_in),
      .deq      (deq),
      .head     (ibuf_head),
      .count    (ibuf_cnt)
   );

endmodule

// File: tb/tb_proc_fetch.sv
// Scoreboard bench for proc_fetch with an in-order random-latency memory.
// Model: epoch-tagged request queue and expected-delivery queue.
module tb_proc_fetch;

   localparam logic [31:0] RPC = 32'h0000_0200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  c2d_pc_sel_F = 2'd0;
   logic [31:0] br_targ_X = '0;
   logic [31:0] jal_targ_D = '0;
   logic [31:0] jr_targ_D = '0;
   logic        imemreq_val;
   logic        imemreq_rdy = 1'b0;
   logic [31:0] imemreq_addr;
   logic        imemresp_val = 1'b0;
   logic [31:0] imemresp_data = '0;
   logic        inst_val_D;
   logic        inst_rdy_D = 1'b0;
   logic [31:0] inst_D;
   logic [31:0] pc_D;

   proc_fetch #(.RESET_PC(RPC)) dut (
      .clk           (clk),
      .rst           (rst),
      .c2d_pc_sel_F  (c2d_pc_sel_F),
      .br_targ_X     (br_targ_X),
      .jal_targ_D    (jal_targ_D),
      .jr_targ_D     (jr_targ_D),
      .imemreq_val   (imemreq_val),
      .imemreq_rdy   (imemreq_rdy),
      .imemreq_addr  (imemreq_addr),
      .imemresp_val  (imemresp_val),
      .imemresp_data (imemresp_data),
      .inst_val_D    (inst_val_D),
      .inst_rdy_D    (inst_rdy_D),
      .inst_D        (inst_D),
      .pc_D          (pc_D)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   req_t        pend[$];
   exp_t        exp_q[$];
   logic [31:0] mpc = RPC;
   int          epoch = 0;
   int          cycle = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          acc_now = 1'b0;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, req, cycle);
      end
   endtask

   // monitor: compares whatever decode is offered against the queue head
   always @(negedge clk) begin
      acc_now = 1'b0;
      if (rst) begin
         chk(!inst_val_D && inst_D == 0 && pc_D == 0, "rst_out",
             {31'b0, inst_val_D} | inst_D | pc_D, 32'h0);
      end else begin
         chk(inst_val_D == (exp_q.size() != 0), "inst_val",
             {31'b0, inst_val_D}, {31'b0, exp_q.size() != 0});
         if (inst_val_D && exp_q.size() != 0) begin
            chk(pc_D == exp_q[0].pc, "pc_D", pc_D, exp_q[0].pc);
            chk(inst_D == exp_q[0].inst, "inst_D", inst_D, exp_q[0].inst);
            if (inst_rdy_D) begin
               void'(exp_q.pop_front());
               acc_now = 1'b1;
            end
         end
      end
   end

   task automatic model_update();
      req_t e;
      bit   ev;
      int   nbuf;
      if (rst) begin
         chk(!imemreq_val, "rst_req_val", {31'b0, imemreq_val}, 32'h0);
         pend.delete();
         exp_q.delete();
         mpc = RPC;
         epoch++;
         return;
      end
      nbuf = exp_q.size() + (acc_now ? 1 : 0);
      ev = (c2d_pc_sel_F == 2'd0) && (pend.size() + nbuf < 3);
      chk(imemreq_val == ev, "req_val", {31'b0, imemreq_val}, {31'b0, ev});
      chk(imemreq_addr == mpc, "req_addr", imemreq_addr, mpc);
      if (imemresp_val) begin
         e = pend.pop_front();
         if (c2d_pc_sel_F == 2'd0 && e.ep == epoch)
            exp_q.push_back('{e.addr, memfn(e.addr)});
      end
      if (c2d_pc_sel_F != 2'd0) begin
         mpc = (c2d_pc_sel_F == 2'd1) ? br_targ_X :
               (c2d_pc_sel_F == 2'd2) ? jal_targ_D : jr_targ_D;
         epoch++;
         exp_q.delete();
      end else if (ev && imemreq_rdy) begin
         pend.push_back('{mpc, epoch,
                          cycle + $urandom_range(lat_hi, lat_lo)});
         mpc = mpc + 32'd4;
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] s,
                      input logic [31:0] t, input logic q_rdy,
                      input logic i_rdy);
      @(posedge clk);
      #1;
      cycle++;
      rst          = r;
      c2d_pc_sel_F = s;
      br_targ_X    = $urandom;
      jal_targ_D   = $urandom;
      jr_targ_D    = $urandom;
      if (s == 2'd1) br_targ_X = t;
      if (s == 2'd2) jal_targ_D = t;
      if (s == 2'd3) jr_targ_D = t;
      imemreq_rdy = q_rdy;
      inst_rdy_D  = i_rdy;
      if (!r && pend.size() > 0 && pend[0].due <= cycle) begin
         imemresp_val  = 1'b1;
         imemresp_data = memfn(pend[0].addr);
      end else begin
         imemresp_val  = 1'b0;
         imemresp_data = $urandom;
      end
      @(negedge clk);
      #2;
      model_update();
   endtask

   task automatic run(input int n, input logic i_rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, i_rdy);
   endtask

   initial begin
      int n;
      cyc(1'b1, 2'd0, 32'h0, 1'b1, 1'b1);
      cyc(1'b1, 2'd0, 32'h0, 1'b1, 1'b1);
      run(15, 1'b1);
      run(5, 1'b0);
      run(10, 1'b1);

      lat_lo = 2; lat_hi = 2;
      n = 0;
      while (pend.size() != 2 && n < 20) begin run(1, 1'b1); n++; end
      chk(n < 20, "wait_2_inflight", n, 20);
      cyc(1'b0, 2'd2, 32'h0000_0300, 1'b1, 1'b1);
      run(12, 1'b1);

      lat_lo = 3; lat_hi = 3;
      n = 0;
      while (!(pend.size() > 1 && pend[0].due <= cycle + 1) && n < 20) begin
         run(1, 1'b1);
         n++;
      end
      chk(n < 20, "wait_resp_cycle", n, 20);
      cyc(1'b0, 2'd1, 32'h0000_0400, 1'b1, 1'b1);
      run(12, 1'b1);

      lat_lo = 1; lat_hi = 1;
      cyc(1'b0, 2'd3, 32'hFFFF_FFF8, 1'b1, 1'b1);
      run(10, 1'b1);

      lat_lo = 3; lat_hi = 3;
      n = 0;
      while (pend.size() + exp_q.size() != 3 && n < 30) begin
         run(1, 1'b0);
         n++;
      end
      chk(n < 30, "wait_full", n, 30);
      cyc(1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
      run(10, 1'b1);

      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] s;
         s = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
         cyc(($urandom_range(299, 0) == 0), s, $urandom & ~32'h3,
             ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
